// File: rtl/pipeline_elastic_reg.sv
// Elastic multi-stage pipeline register with valid/ready on both sides.
// Ports: clk, reset (sync, active-low), enable (freeze when 0), flush,
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data
//        downstream, count = number of occupied stages.
// All state changes on the falling edge of clk.
module pipeline_elastic_reg #(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 2,
   parameter bit ZERO_ON_FLUSH = 1'b1,
   parameter int CW            = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH:0]   rdy;
   logic [DEPTH-1:0] valid_nxt;
   logic [CW-1:0]    count_nxt;
   logic             run;

   assign run = enable & ~flush;

   // A stage can advance if it is empty or everything ahead of it
   // advances; a local accumulator keeps the chain free of self-loops.
   always_comb begin : ready_chain
      logic r;
      r          = out_ready;
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         r      = ~valid[k] | r;
         rdy[k] = r;
      end
   end

   always_comb begin
      valid_nxt = valid;
      if (rdy[0]) valid_nxt[0] = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
         if (rdy[k]) valid_nxt[k] = valid[k-1];
      end
      count_nxt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         count_nxt = count_nxt + CW'(valid_nxt[k]);
      end
   end

   always_ff @(negedge clk) begin
      if (!reset) begin
         valid <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) data[k] <= '0;
      end else if (flush) begin
         valid <= '0;
         count <= '0;
         if (ZERO_ON_FLUSH) begin
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
         end
      end else if (enable) begin
         valid <= valid_nxt;
         count <= count_nxt;
         if (rdy[0]) data[0] <= in_data;
         // Bubbles never overwrite payload: data only moves with a valid item.
         for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k] && valid[k-1]) data[k] <= data[k-1];
         end
      end
   end

   assign in_ready  = rdy[0] & run;
   assign out_valid = valid[DEPTH-1] & run;
   assign out_data  = data[DEPTH-1];

endmodule
